// File: rtl/orb_fast_ram_arbiter.sv
// Round-robin arbiter sharing the single-port FAST keypoint SRAM between the
// detector write stream and the circle-drawer read stream.
module orb_fast_ram_arbiter #(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 1,
    parameter int AW          = $clog2(X_MAX) + 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   wr_req,
    input  logic [AW-1:0]          wr_x,
    input  logic [AW-1:0]          wr_y,
    input  logic [PIXEL_DEPTH-1:0] wr_dat,
    output logic                   wr_gnt,
    input  logic                   rd_req,
    input  logic [AW-1:0]          rd_x,
    input  logic [AW-1:0]          rd_y,
    output logic                   rd_gnt,
    output logic                   rd_valid,
    output logic [PIXEL_DEPTH-1:0] rd_dat,
    output logic [AW-1:0]          x_addr,
    output logic [AW-1:0]          y_addr,
    output logic                   wen,
    output logic                   ren,
    output logic [PIXEL_DEPTH-1:0] wdat,
    input  logic [PIXEL_DEPTH-1:0] rdat
);

    logic [AW-1:0] req_x [2];
    logic [AW-1:0] req_y [2];
    logic [1:0]    in_range;

    assign req_x[0] = wr_x;
    assign req_y[0] = wr_y;
    assign req_x[1] = rd_x;
    assign req_y[1] = rd_y;

    // Coordinates are two's complement; sign-extend before comparing against the image size.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bounds
            logic signed [31:0] sx;
            logic signed [31:0] sy;
            assign sx = 32'(signed'(req_x[gi]));
            assign sy = 32'(signed'(req_y[gi]));
            assign in_range[gi] = (sx >= 0) && (sx < X_MAX) && (sy >= 0) && (sy < Y_MAX);
        end
    endgenerate

    logic last_rd_reg;
    logic wr_win;
    logic rd_win;

    always_comb begin
        wr_win = wr_req && (!rd_req || last_rd_reg);
        rd_win = rd_req && !wr_win;
    end

    assign wr_gnt = wr_win;
    assign rd_gnt = rd_win;

    logic [AW-1:0]          x_addr_reg;
    logic [AW-1:0]          y_addr_reg;
    logic [PIXEL_DEPTH-1:0] wdat_reg;
    logic                   wen_reg;
    logic                   ren_reg;
    logic                   s1_rd_reg;
    logic                   s1_inr_reg;
    logic                   rd_valid_reg;
    logic                   s2_inr_reg;
    logic [PIXEL_DEPTH-1:0] rd_hold_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_rd_reg  <= 1'b1;
            x_addr_reg   <= '0;
            y_addr_reg   <= '0;
            wdat_reg     <= '0;
            wen_reg      <= 1'b0;
            ren_reg      <= 1'b0;
            s1_rd_reg    <= 1'b0;
            s1_inr_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
            s2_inr_reg   <= 1'b0;
            rd_hold_reg  <= '0;
        end else begin
            // Out-of-range grants still flow down the pipe so reads return a (zero) result.
            wen_reg    <= wr_win && in_range[0];
            ren_reg    <= rd_win && in_range[1];
            s1_rd_reg  <= rd_win;
            s1_inr_reg <= in_range[1];
            if (wr_win) begin
                x_addr_reg  <= wr_x;
                y_addr_reg  <= wr_y;
                wdat_reg    <= wr_dat;
                last_rd_reg <= 1'b0;
            end else if (rd_win) begin
                x_addr_reg  <= rd_x;
                y_addr_reg  <= rd_y;
                last_rd_reg <= 1'b1;
            end
            rd_valid_reg <= s1_rd_reg;
            s2_inr_reg   <= s1_inr_reg;
            if (rd_valid_reg) begin
                rd_hold_reg <= rd_dat;
            end
        end
    end

    // SRAM data arrives in the rd_valid cycle, so it is steered through combinationally.
    always_comb begin
        rd_dat = rd_hold_reg;
        if (rd_valid_reg) begin
            rd_dat = s2_inr_reg ? rdat : '0;
        end
    end

    assign rd_valid = rd_valid_reg;
    assign x_addr   = x_addr_reg;
    assign y_addr   = y_addr_reg;
    assign wdat     = wdat_reg;
    assign wen      = wen_reg;
    assign ren      = ren_reg;

endmodule

// File: tb/tb_orb_fast_ram_arbiter.sv
// Bench for orb_fast_ram_arbiter: SRAM model, reference scoreboard, vector table,
// directed corner sequences and randomized traffic.
module tb_orb_fast_ram_arbiter;

    localparam int X_MAX = 400;
    localparam int Y_MAX = 400;
    localparam int AW    = $clog2(X_MAX) + 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_x = '0, wr_y = '0, rd_x = '0, rd_y = '0;
    logic [0:0]    wr_dat = '0;
    logic          wr_gnt, rd_gnt, rd_valid, wen, ren;
    logic [0:0]    rd_dat, wdat;
    logic [0:0]    rdat = '0;
    logic [AW-1:0] x_addr, y_addr;

    orb_fast_ram_arbiter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .PIXEL_DEPTH(1)) dut (
        .clk(clk), .n_rst(n_rst),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_dat(wr_dat), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_dat(rd_dat),
        .x_addr(x_addr), .y_addr(y_addr), .wen(wen), .ren(ren), .wdat(wdat), .rdat(rdat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit inb(logic [AW-1:0] x, logic [AW-1:0] y);
        int xi, yi;
        xi = $signed(x);
        yi = $signed(y);
        return xi >= 0 && xi < X_MAX && yi >= 0 && yi < Y_MAX;
    endfunction

    function automatic int idx(logic [AW-1:0] x, logic [AW-1:0] y);
        int xi, yi;
        xi = $signed(x);
        yi = $signed(y);
        return yi * X_MAX + xi;
    endfunction

    function automatic logic [AW-1:0] c(int v);
        return v[AW-1:0];
    endfunction

    // SRAM behavioural model with registered read.
    bit sram   [0:X_MAX*Y_MAX-1];
    bit refmem [0:X_MAX*Y_MAX-1];
    int cnt_overlap = 0, cnt_oob = 0, cnt_wen = 0, cnt_rdv = 0;

    always @(posedge clk) begin
        if (ren && inb(x_addr, y_addr)) rdat <= sram[idx(x_addr, y_addr)];
        if (wen && inb(x_addr, y_addr)) sram[idx(x_addr, y_addr)] <= wdat[0];
    end

    always @(negedge clk) begin
        if (wen && ren) cnt_overlap++;
        if ((wen || ren) && !inb(x_addr, y_addr)) cnt_oob++;
        if (wen) cnt_wen++;
        if (rd_valid) cnt_rdv++;
    end

    // Scoreboard: transfers in grant order against a reference memory image.
    typedef struct { int due; bit d; } rexp_t;
    rexp_t         rq[$];
    int            cyc = 0;
    bit            m_last_rd = 1'b1;
    int            m_kind = 0;
    bit            m_inr = 1'b0, m_d = 1'b0, m_wd = 1'b0, m_rhold = 1'b0;
    logic [AW-1:0] m_px = '0, m_py = '0, m_ax = '0, m_ay = '0;
    bit            ew, er;

    always @(negedge clk) begin
        if (!n_rst) begin
            rq.delete();
            m_last_rd = 1'b1; m_kind = 0; m_ax = '0; m_ay = '0; m_wd = 1'b0; m_rhold = 1'b0;
        end else begin
            cyc++;
            if (m_kind != 0) begin
                m_ax = m_px; m_ay = m_py;
                if (m_kind == 1) m_wd = m_d;
            end
            check("sb_wen", int'(wen), int'(m_kind == 1 && m_inr));
            check("sb_ren", int'(ren), int'(m_kind == 2 && m_inr));
            check("sb_x_addr", int'(x_addr), int'(m_ax));
            check("sb_y_addr", int'(y_addr), int'(m_ay));
            check("sb_wdat", int'(wdat), int'(m_wd));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                check("sb_rd_valid", int'(rd_valid), 1);
                check("sb_rd_dat", int'(rd_dat), int'(rq[0].d));
                m_rhold = rq[0].d;
                void'(rq.pop_front());
            end else begin
                check("sb_rd_valid", int'(rd_valid), 0);
                check("sb_rd_hold", int'(rd_dat), int'(m_rhold));
            end
            ew = wr_req && (!rd_req || m_last_rd);
            er = rd_req && !ew;
            check("sb_wr_gnt", int'(wr_gnt), int'(ew));
            check("sb_rd_gnt", int'(rd_gnt), int'(er));
            m_kind = 0;
            if (ew) begin
                m_kind = 1; m_px = wr_x; m_py = wr_y; m_d = wr_dat[0]; m_inr = inb(wr_x, wr_y);
                m_last_rd = 1'b0;
                if (m_inr) refmem[idx(wr_x, wr_y)] = wr_dat[0];
            end else if (er) begin
                m_kind = 2; m_px = rd_x; m_py = rd_y; m_inr = inb(rd_x, rd_y);
                m_last_rd = 1'b1;
                rq.push_back('{due: cyc + 2, d: (m_inr ? refmem[idx(rd_x, rd_y)] : 1'b0)});
            end
        end
    end

    typedef struct {
        bit wr, rd; int wx, wy; bit wd; int rx, ry; bit exp_w, exp_r;
    } vec_t;
    vec_t vecs[11];

    task automatic drive_idle();
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_x_addr"}, int'(x_addr), 0);
        check({tag, "_y_addr"}, int'(y_addr), 0);
        check({tag, "_wen"}, int'(wen), 0);
        check({tag, "_ren"}, int'(ren), 0);
        check({tag, "_wdat"}, int'(wdat), 0);
        check({tag, "_rd_valid"}, int'(rd_valid), 0);
        check({tag, "_rd_dat"}, int'(rd_dat), 0);
    endtask

    function automatic int rcoord(int maxv);
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, maxv + 15)) - 8;
    endfunction

    int w0, r0, diffs;
    bit wg, rg;

    initial begin
        for (int i = 0; i < 6; i++)
            vecs[i] = '{1, 1, i + 1, 0, 1'(i), i + 1, 1, (i % 2) == 0, (i % 2) == 1};
        vecs[6]  = '{1, 0, 20, 2, 1, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 20, 2, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 1, 21, 2, 1, 21, 3, 1, 0};
        vecs[10] = '{1, 1, 21, 2, 1, 21, 3, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 n_rst = 1'b1;

        // Arbitration vector table, starting from a fresh tie
        w0 = cnt_wen; r0 = cnt_rdv;
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            wr_req = vecs[i].wr; wr_x = c(vecs[i].wx); wr_y = c(vecs[i].wy); wr_dat = vecs[i].wd;
            rd_req = vecs[i].rd; rd_x = c(vecs[i].rx); rd_y = c(vecs[i].ry);
            @(negedge clk);
            check($sformatf("vec%0d_wr_gnt", i), int'(wr_gnt), int'(vecs[i].exp_w));
            check($sformatf("vec%0d_rd_gnt", i), int'(rd_gnt), int'(vecs[i].exp_r));
        end
        @(posedge clk); #1 drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("vec_wen_pulses", cnt_wen - w0, 5);
        check("vec_rd_valid_pulses", cnt_rdv - r0, 5);

        // Write only
        wr_req = 1'b1; wr_x = c(10); wr_y = c(20); wr_dat = 1'b1;
        @(negedge clk); check("wo_gnt", int'(wr_gnt), 1);
        @(posedge clk); #1 drive_idle();
        @(negedge clk);
        check("wo_wen", int'(wen), 1); check("wo_ren", int'(ren), 0);
        check("wo_x", int'(x_addr), 10); check("wo_y", int'(y_addr), 20); check("wo_wdat", int'(wdat), 1);

        // Read latency after preloading (5,5)=1
        @(posedge clk); #1 wr_req = 1'b1; wr_x = c(5); wr_y = c(5); wr_dat = 1'b1;
        @(posedge clk); #1 drive_idle();
        @(posedge clk); #1 rd_req = 1'b1; rd_x = c(5); rd_y = c(5);
        @(negedge clk); check("rl_gnt", int'(rd_gnt), 1);
        @(posedge clk); #1 drive_idle();
        @(negedge clk); check("rl_ren", int'(ren), 1); check("rl_valid_n1", int'(rd_valid), 0);
        @(negedge clk); check("rl_valid_n2", int'(rd_valid), 1); check("rl_dat", int'(rd_dat), 1);
        @(negedge clk); check("rl_valid_n3", int'(rd_valid), 0);

        // Out-of-range coordinates
        @(posedge clk); #1 wr_req = 1'b1; wr_x = c(-1); wr_y = c(0); wr_dat = 1'b1;
        @(negedge clk); check("oob_w1_gnt", int'(wr_gnt), 1);
        @(posedge clk); #1 wr_x = c(400); wr_y = c(3);
        @(negedge clk); check("oob_w2_gnt", int'(wr_gnt), 1); check("oob_w1_wen", int'(wen), 0);
        @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b1; rd_x = c(0); rd_y = c(400);
        @(negedge clk); check("oob_r_gnt", int'(rd_gnt), 1); check("oob_w2_wen", int'(wen), 0);
        @(posedge clk); #1 drive_idle();
        @(negedge clk); check("oob_r_ren", int'(ren), 0);
        @(negedge clk); check("oob_r_valid", int'(rd_valid), 1); check("oob_r_dat", int'(rd_dat), 0);

        // Write then read of the same pixel on consecutive grants
        @(posedge clk); #1 wr_req = 1'b1; wr_x = c(7); wr_y = c(7); wr_dat = 1'b1;
        @(negedge clk); check("raw_w_gnt", int'(wr_gnt), 1);
        @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b1; rd_x = c(7); rd_y = c(7);
        @(negedge clk); check("raw_r_gnt", int'(rd_gnt), 1);
        @(posedge clk); #1 drive_idle();
        @(negedge clk); check("raw_valid_early", int'(rd_valid), 0);
        @(negedge clk); check("raw_valid", int'(rd_valid), 1); check("raw_dat", int'(rd_dat), 1);

        // Reset while a read is in flight
        @(posedge clk); #1 rd_req = 1'b1; rd_x = c(3); rd_y = c(4);
        @(negedge clk); check("mr_gnt", int'(rd_gnt), 1);
        @(posedge clk); #1 n_rst = 1'b0; drive_idle();
        #1 check_all_zero("mr_in_reset");
        @(posedge clk);
        @(posedge clk); #1 n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check($sformatf("mr_no_valid%0d", i), int'(rd_valid), 0);
        end
        @(posedge clk); #1 wr_req = 1'b1; rd_req = 1'b1; wr_x = c(30); wr_y = c(30); rd_x = c(31); rd_y = c(31);
        @(negedge clk); check("mr_tie_wr", int'(wr_gnt), 1); check("mr_tie_rd", int'(rd_gnt), 0);
        @(posedge clk); #1 drive_idle();

        // Randomized traffic, checked by the scoreboard; requests held until granted
        wg = 1'b0; rg = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!wr_req || wg) begin
                wr_req = 1'($urandom_range(0, 1));
                wr_x = c(rcoord(X_MAX)); wr_y = c(rcoord(Y_MAX)); wr_dat = 1'($urandom_range(0, 1));
            end
            if (!rd_req || rg) begin
                rd_req = 1'($urandom_range(0, 1));
                rd_x = c(rcoord(X_MAX)); rd_y = c(rcoord(Y_MAX));
            end
            @(negedge clk); wg = wr_gnt; rg = rd_gnt;
        end
        @(posedge clk); #1 drive_idle();
        repeat (4) @(posedge clk);
        #1;

        check("pending_reads", rq.size(), 0);
        check("wen_ren_overlap", cnt_overlap, 0);
        check("sram_oob_access", cnt_oob, 0);
        diffs = 0;
        for (int i = 0; i < X_MAX * Y_MAX; i++) if (sram[i] != refmem[i]) diffs++;
        check("sram_contents", diffs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
